// File: rtl/tinyqv_serial_pkg.sv
// tinyqv_serial_pkg: constants shared by the nibble-serial word units.
package tinyqv_serial_pkg;
    localparam int NIBBLE_W = 4;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] FRAME_LAST = 3'b111;
    localparam int WORD_W = 32;
endpackage

// File: rtl/tinyqv_nibble_shreg.sv
// tinyqv_nibble_shreg: parallel-load, right-shift-by-one-nibble register.
module tinyqv_nibble_shreg
    import tinyqv_serial_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic                clk,
    input  logic                i_clear,
    input  logic                i_load,
    input  logic                i_shift,
    input  logic [W-1:0]        i_data,
    output logic [NIBBLE_W-1:0] o_nibble
);
    logic [W-1:0] r_q;
    always_ff @(posedge clk) begin
        if (i_clear) r_q <= '0;
        else if (i_load) r_q <= i_data;
        else if (i_shift) r_q <= r_q >> NIBBLE_W;
    end
    assign o_nibble = r_q[NIBBLE_W-1:0];
endmodule

// File: rtl/tinyqv_nibble_tx.sv
// tinyqv_nibble_tx: 32-bit valid/ready words to LSB-first nibble frames
// aligned to the shared nibble counter.
module tinyqv_nibble_tx
    import tinyqv_serial_pkg::*;
#(
    parameter int NIBBLES         = 8,
    parameter bit STICKY_UNDERRUN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [CNT_W-1:0]        counter,
    input  logic [NIBBLES*NIBBLE_W-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NIBBLE_W-1:0]     out_nibble,
    output logic                    out_valid,
    output logic                    out_last,
    output logic                    underrun,
    input  logic                    underrun_clr
);
    localparam int W = NIBBLES * NIBBLE_W;
    logic [W-1:0]        r_pend;
    logic                r_pend_full;
    logic                r_act_valid;
    logic                r_underrun;
    logic                w_last;
    logic                w_acc;
    logic                w_set;
    logic [NIBBLE_W-1:0] w_nibble;
    assign w_last = counter == FRAME_LAST;
    assign in_ready = !r_pend_full | w_last;
    assign w_acc = in_valid & in_ready;
    assign w_set = w_last & r_act_valid & !r_pend_full;
    // The pending slot hands over and refills on the same boundary edge.
    tinyqv_nibble_shreg #(.W(W)) u_shreg (
        .clk      (clk),
        .i_clear  (!rstn | (w_last & !r_pend_full)),
        .i_load   (w_last & r_pend_full),
        .i_shift  (!w_last),
        .i_data   (r_pend),
        .o_nibble (w_nibble)
    );
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_act_valid <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            if (w_acc) r_pend <= in_data;
            r_pend_full <= w_last ? w_acc : (r_pend_full | w_acc);
            if (w_last) r_act_valid <= r_pend_full;
            r_underrun <= STICKY_UNDERRUN ? (w_set | (r_underrun & !underrun_clr)) : w_set;
        end
    end
    assign out_nibble = r_act_valid ? w_nibble : '0;
    assign out_valid = r_act_valid;
    assign out_last = r_act_valid & w_last;
    assign underrun = r_underrun;
endmodule

// File: tb/tb_tinyqv_nibble_tx.sv
// tb_tinyqv_nibble_tx: directed scenario tests for the nibble transmitter,
// with a second instance in pulse-underrun mode.
module tb_tinyqv_nibble_tx;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  counter = 3'd0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        in_ready, out_valid, out_last, underrun;
    logic [3:0]  out_nibble;
    logic        p_in_ready, p_out_valid, p_out_last, p_underrun;
    logic [3:0]  p_out_nibble;
    int          n_tests = 0;
    int          n_fail = 0;

    tinyqv_nibble_tx dut (
        .clk(clk), .rstn(rstn), .counter(counter), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_nibble(out_nibble), .out_valid(out_valid), .out_last(out_last),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );
    tinyqv_nibble_tx #(.STICKY_UNDERRUN(1'b0)) dut_p (
        .clk(clk), .rstn(rstn), .counter(counter), .in_data(in_data), .in_valid(in_valid),
        .in_ready(p_in_ready), .out_nibble(p_out_nibble), .out_valid(p_out_valid), .out_last(p_out_last),
        .underrun(p_underrun), .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) counter <= counter + 3'd1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic wait_cnt(input logic [2:0] k);
        int n;
        n = 0;
        @(negedge clk);
        while (counter !== k && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (counter !== k) begin
            n_tests++; n_fail++;
            $display("FAIL wait_cnt: counter=%0d required=%0d", counter, k);
        end
    endtask

    task automatic clear_underrun();
        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_tests++;
            if ({out_valid, out_nibble, in_ready, underrun} !== 7'b0_0000_1_0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: valid=%b nib=%h ready=%b ur=%b required 0 0 1 0",
                         i, out_valid, out_nibble, in_ready, underrun);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] w;
        w = 32'h87654321;
        wait_cnt(3'd2);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b required 1", in_ready); end
        in_data = w; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt(3'd0);
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_nibble !== w[4*i +: 4] || out_last !== (i == 7)) begin
                n_fail++;
                $display("FAIL single_frame c%0d: valid=%b nib=%h last=%b required 1 %h %b",
                         i, out_valid, out_nibble, out_last, w[4*i +: 4], i == 7);
            end
            @(negedge clk);
        end
        n_tests++;
        if (out_valid !== 1'b0 || out_nibble !== 4'h0) begin
            n_fail++;
            $display("FAIL single_after: valid=%b nib=%h required 0 0", out_valid, out_nibble);
        end
        clear_underrun();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_n [16] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD,
                                    4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
        wait_cnt(3'd1);
        in_data = 32'hDEADBEEF; in_valid = 1'b1;
        @(negedge clk);
        in_data = 32'h01234567;
        while (counter !== 3'd7) begin
            n_tests++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_holdoff c%0d: ready=%b required 0", counter, in_ready); end
            @(negedge clk);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_c7: ready=%b required 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_nibble !== exp_n[i] || underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_frame i%0d: valid=%b nib=%h ur=%b required 1 %h 0",
                         i, out_valid, out_nibble, underrun, exp_n[i]);
            end
            @(negedge clk);
        end
        clear_underrun();
    endtask

    task automatic test_underrun();
        wait_cnt(3'd3);
        in_data = 32'hA5A5A5A5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt(3'd0);
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (out_nibble !== ((i % 2) ? 4'hA : 4'h5) || underrun !== 1'b0 || p_underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL ur_frame c%0d: nib=%h ur=%b pur=%b required %h 0 0",
                         i, out_nibble, underrun, p_underrun, (i % 2) ? 4'hA : 4'h5);
            end
            @(negedge clk);
        end
        n_tests++;
        if ({out_valid, out_nibble, underrun, p_underrun} !== 7'b0_0000_1_1) begin
            n_fail++;
            $display("FAIL ur_set: valid=%b nib=%h ur=%b pur=%b required 0 0 1 1",
                     out_valid, out_nibble, underrun, p_underrun);
        end
        @(negedge clk);
        n_tests++;
        if (underrun !== 1'b1 || p_underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ur_hold: ur=%b pur=%b required 1 0", underrun, p_underrun);
        end
        wait_cnt(3'd0);
        n_tests++;
        if (underrun !== 1'b1 || p_underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ur_sticky_idle: ur=%b pur=%b required 1 0", underrun, p_underrun);
        end
        clear_underrun();
        n_tests++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear: ur=%b required 0", underrun); end
        // Set and clear on the same boundary: set must win.
        wait_cnt(3'd4);
        in_data = 32'h11111111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt(3'd7);
        wait_cnt(3'd7);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        n_tests++;
        if (underrun !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ur_set_wins: ur=%b valid=%b required 1 0", underrun, out_valid);
        end
        clear_underrun();
    endtask

    task automatic test_reset_mid();
        wait_cnt(3'd6);
        in_data = 32'hFFFFFFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt(3'd1);
        in_data = 32'h12345678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt(3'd4);
        n_tests++;
        if (out_valid !== 1'b1 || out_nibble !== 4'hF || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_before: valid=%b nib=%h ready=%b required 1 f 0", out_valid, out_nibble, in_ready);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_tests++;
        if (out_valid !== 1'b0 || out_nibble !== 4'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_after: valid=%b nib=%h ready=%b required 0 0 1", out_valid, out_nibble, in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0 || underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_noframe i%0d: valid=%b ur=%b required 0 0", i, out_valid, underrun);
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] w;
        w = 32'h0F1E2D3C;
        wait_cnt(3'd7);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bnd_ready: ready=%b required 1", in_ready); end
        in_data = w; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bnd_pending: ready=%b required 0", in_ready); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (out_valid !== 1'b0 || out_nibble !== 4'h0 || underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL bnd_idle c%0d: valid=%b nib=%h ur=%b required 0 0 0", i, out_valid, out_nibble, underrun);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_nibble !== w[4*i +: 4]) begin
                n_fail++;
                $display("FAIL bnd_frame c%0d: valid=%b nib=%h required 1 %h", i, out_valid, out_nibble, w[4*i +: 4]);
            end
            @(negedge clk);
        end
        clear_underrun();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tinyqv_nibble_tx.md
Name: tinyqv_nibble_tx

Overview:
Parallel-to-nibble-serial transmitter for the core's 4-bit datapath. It is the producing end of the nibble-serial word interface that tinyqv_counter and the other serial units consume.
- Accepts 32-bit words through a valid/ready handshake.
- Emits each word LSB-nibble first over one 8-cycle frame, aligned to the shared 3-bit nibble counter.
- Feeds serial units (e.g. a counter preload, a serial compare) from parallel sources such as CSR writes.

Parameters:
NIBBLES, 8, nibbles per word; word width is 4*NIBBLES; counter width is clog2(NIBBLES); only 8 is supported in this revision.
STICKY_UNDERRUN, 1, 1 = underrun flag holds until underrun_clr; 0 = underrun is a one-cycle pulse.

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
counter  input  3  shared free-running nibble index; increments by 1 each cycle, wraps 7->0
in_data  input  32  word to transmit
in_valid  input  1  in_data valid
in_ready  output  1  word accepted this cycle when in_valid & in_ready
out_nibble  output  4  nibble number counter of the active word; 0 when idle
out_valid  output  1  active frame carries a word
out_last  output  1  out_valid & (counter==7)
underrun  output  1  frame boundary passed with no pending word after a valid frame
underrun_clr  input  1  clears sticky underrun

Behaviour:
- Storage:
  - pending register: 32 bits data plus pend_full.
  - active shift register: 32 bits plus act_valid.
- Reset (rstn=0 at a clk edge): pend_full=0, act_valid=0, shift=0, underrun=0. Reset mid-frame aborts the frame; out_nibble=0 and out_valid=0 from the next cycle.
- Outputs:
  - out_nibble = act_valid ? shift[3:0] : 0.
  - out_valid = act_valid.
  - All outputs are combinational from registers and counter only; no path from in_valid.
- in_ready = !pend_full | (counter==7). At the frame boundary the pending slot frees the same edge it is refilled.
- Edge with counter != 7:
  - shift >>= 4 (zero fill).
  - Accept: if in_valid & in_ready, pending <= in_data and pend_full <= 1.
- Edge with counter == 7 (frame boundary):
  - If pend_full: shift <= pending, act_valid <= 1. Else: act_valid <= 0, shift <= 0.
  - pend_full <= (in_valid & in_ready); pending <= in_data when accepted. A simultaneous accept and transfer is legal: the old pending word moves to active, the new word moves to pending.
  - A word accepted at counter==7 is transmitted in the frame after next, not the immediate one.
- Latency: a word accepted at counter=k with pending empty appears as nibble 0 on the first counter==0 after the next counter==7 edge, i.e. 8-k cycles after acceptance (acceptance at counter==7 is the exception above).
- Throughput: one word per 8 cycles sustained, with no bubbles if the source keeps pending full.
- Underrun:
  - Set at a counter==7 edge when act_valid=1 and pend_full=0.
  - Sticky mode: holds until an edge with underrun_clr=1. Set wins over a simultaneous clear.
  - Pulse mode: high for exactly one cycle (counter==0).
- Idle start: after reset or idle, the first word does not underrun-flag its own predecessor, because act_valid was 0.
- Counter discontinuity is not detected; the counter must be free-running as in the core.

Decomposition:
- Shared package tinyqv_serial_pkg: NIBBLE_W=4, CNT_W=3, FRAME_LAST=3'b111, WORD_W=32. The receiving and serial-arithmetic blocks reuse the same constants.
- Optional sub-module tinyqv_nibble_shreg: 32-bit parallel-load / right-shift-by-4 register with load, shift and clear controls. The handshake and underrun logic stay in the top module.

Test Plan:
1. Reset, counter running, in_valid=0 -> out_valid=0, out_nibble=0, in_ready=1, underrun=0 for 16 cycles.
2. Offer 0x87654321 at counter=2 -> accepted that cycle; on the next frame out_nibble = 1,2,3,4,5,6,7,8 for counter 0..7; out_last=1 only at counter=7.
3. Back-to-back 0xDEADBEEF then 0x01234567, source always valid -> second word held off (in_ready=0) until counter=7; frames F,E,E,B,D,A,E,D then 7,6,5,4,3,2,1,0 with no gap; underrun stays 0.
4. Single word 0xA5A5A5A5 then no more -> after its frame out_valid=0 and out_nibble=0; underrun=1 from counter=0 and stays 1 until underrun_clr. With STICKY_UNDERRUN=0 it is high for exactly one cycle.
5. Assert rstn=0 at counter=4 mid-frame of 0xFFFFFFFF with a pending word -> next cycle out_valid=0, in_ready=1; the pending word is discarded and no frame appears at the next boundary.
6. Offer exactly at counter=7 with pending empty, active idle -> accepted; the next frame is idle; the word is emitted in the following frame.
